srl_bus_sink_fifo: RTL
======================

// Module: srl_bus_sink_fifo
// PURPOSE
//  Receiving end of a fixed-latency SRL_bus delay line. The upstream issues words into an
//  SRL_bus of C_LATENCY cycles; the words land here after that delay. This block buffers
//  them in a first-word-fall-through FIFO with a valid/ready read port. It returns a
//  credit signal (issue_ok) that counts in-flight words, so the delay line never overruns.
// PARAMETERS
//  C_DATA_WIDTH  32  width of each data word
//  C_LATENCY     4   upstream SRL_bus delay in cycles, from issue to wr_valid (>=1)
//  C_DEPTH       16  FIFO entries; power of 2, >= C_LATENCY+2
// PORTS
//  clk        in   1              single clock, all logic posedge
//  rst        in   1              synchronous, active-high reset
//  issue      in   1              upstream launches a word into the delay line this cycle
//  issue_ok   out  1              credit available; upstream may assert issue only when 1
//  wr_valid   in   1              delayed valid from the SRL_bus output
//  wr_data    in   C_DATA_WIDTH   delayed data from the SRL_bus output
//  rd_valid   out  1              FIFO head valid (count != 0)
//  rd_ready   in   1              consumer accepts head when rd_valid & rd_ready
//  rd_data    out  C_DATA_WIDTH   FIFO head word, FWFT
//  count      out  clog2(C_DEPTH)+1  current FIFO occupancy
//  inflight   out  clog2(C_DEPTH)+1  words issued but not yet arrived
//  overflow   out  1              sticky: a word was dropped because the FIFO was full
//  proto_err  out  1              sticky: wr_valid arrived while inflight==0
// BEHAVIOUR
//  Reset: rd_ptr=wr_ptr=0, count=0, inflight=0, overflow=0, proto_err=0, rd_valid=0.
//    issue_ok is forced to 0 while rst is high. Memory contents are don't-care.
//  Read: rd_valid=(count!=0). rd_data=mem[rd_ptr] combinationally (FWFT).
//    On rd_valid & rd_ready, rd_ptr advances next cycle.
//    rd_ready while rd_valid=0 is ignored.
//  Write: on wr_valid, if count<C_DEPTH or a read fires this cycle, then mem[wr_ptr]<=wr_data
//    and wr_ptr advances. Otherwise the word is dropped and overflow<=1.
//  Pointers: log2(C_DEPTH) bits, wrap naturally from C_DEPTH-1 to 0.
//  count_next = count + write_acc - read_acc. A simultaneous read and write leaves count unchanged.
//  inflight_next = inflight + issue - wr_valid.
//    If wr_valid while inflight==0 and no issue: hold inflight at 0 (no underflow) and set proto_err<=1.
//    issue and wr_valid in the same cycle: net 0.
//  Credit: issue_ok = !rst & ((count + inflight) < C_DEPTH).
//    Computed combinationally from registers only, never from issue/wr_valid in the same cycle.
//    After one issue in cycle N, issue_ok reflects it from cycle N+1.
//  The credit rule guarantees count+inflight <= C_DEPTH. Overflow is therefore reachable only
//    if the upstream ignores issue_ok.
//  Latency: wr_valid in cycle N gives rd_valid=1 in cycle N+1 (empty FIFO).
//    Issue-to-read is C_LATENCY+1 cycles.
//  Reset mid-operation: all in-flight and buffered words are discarded. Sticky flags clear.
//    Upstream must also reset its SRL_bus on the same rst.
//  Flags clear only on rst.
// TESTING
//  1 After reset: issue_ok=0 during rst; 1 cycle after rst falls, issue_ok=1, rd_valid=0, count=0, inflight=0.
//  2 Single word, C_LATENCY=4: issue@t0 with SRL data 0xA5A5_0001 -> inflight=1@t1, wr_valid@t4,
//    rd_valid=1 & rd_data=0xA5A5_0001@t5, inflight=0.
//  3 Credit throttle: rd_ready=0, upstream issues whenever issue_ok -> exactly 16 issues,
//    count reaches 16, issue_ok=0 then, overflow stays 0.
//  4 Full + simultaneous R/W: count=16, rd_ready=1 & wr_valid=1 in the same cycle -> count stays 16,
//    no overflow, output order 0..N preserved across pointer wrap.
//  5 Errors: force wr_valid with inflight=0 -> proto_err=1, inflight=0. Force wr_valid at count=16
//    with rd_ready=0 -> overflow=1, count=16. Both flags clear only on rst.
//  6 Random issue/rd_ready at 50% for 10k cycles vs scoreboard -> data in order, no loss,
//    count+inflight<=16 always.

Source files
------------

// File: rtl/srl_bus_sink_fifo.sv
// srl_bus_sink_fifo: FWFT FIFO at the tail of a fixed-latency SRL_bus, with issue credit
// Ports: clk/rst (sync, active-high); issue/issue_ok upstream launch and credit;
// wr_valid/wr_data delayed words from the SRL_bus; rd_valid/rd_ready/rd_data FWFT read port;
// count/inflight occupancy and outstanding words; overflow/proto_err sticky error flags.
module srl_bus_sink_fifo #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_LATENCY = 4,
  parameter int C_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue,
  output logic                        issue_ok,
  input  logic                        wr_valid,
  input  logic [C_DATA_WIDTH-1:0]     wr_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [C_DATA_WIDTH-1:0]     rd_data,
  output logic [$clog2(C_DEPTH):0]    count,
  output logic [$clog2(C_DEPTH):0]    inflight,
  output logic                        overflow,
  output logic                        proto_err
);
  localparam int AW = $clog2(C_DEPTH);
  localparam int CW = AW + 1;
  if (C_LATENCY < 1 || C_DEPTH < C_LATENCY + 2 || (1 << AW) != C_DEPTH) begin : g_bad_cfg
    $error("srl_bus_sink_fifo: bad C_LATENCY/C_DEPTH");
  end
  logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic rd_acc, wr_acc, under;
  logic [CW:0] credit_sum;
  assign rd_valid = count != '0;
  assign rd_data = mem[rd_ptr];
  assign rd_acc = rd_valid & rd_ready;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign wr_acc = wr_valid & ((count < CW'(C_DEPTH)) | rd_acc);
  // arrival with nothing outstanding and no compensating issue: clamp instead of wrapping
  assign under = wr_valid & ~issue & (inflight == '0);
  assign credit_sum = {1'b0, count} + {1'b0, inflight};
  assign issue_ok = ~rst & (credit_sum < (CW + 1)'(C_DEPTH));
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      inflight <= '0;
      overflow <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + AW'(rd_acc);
      wr_ptr <= wr_ptr + AW'(wr_acc);
      count <= count + CW'(wr_acc) - CW'(rd_acc);
      inflight <= under ? '0 : inflight + CW'(issue) - CW'(wr_valid);
      overflow <= overflow | (wr_valid & ~wr_acc);
      proto_err <= proto_err | under;
    end
endmodule
